pht_access_ctrl: RTL and testbench

//  Gshare front-end for the 2-bit pattern history table (PHT).
//  - Owns the speculative global history register (GHR).
//  - Forms the index pc^GHR.
//  - Arbitrates the PHT's single index port between fetch predictions and execute-stage resolved-branch updates.
//  - Repairs the GHR on mispredicts.
//  - Sits between the fetch unit, the branch unit and the PHT; performs no PHT initialisation.

---
 rtl/bp_pkg.sv | 30 +++
 rtl/pht_access_ctrl_if.sv | 47 ++++
 rtl/bp_upd_fifo.sv | 45 ++++
 rtl/pht_access_ctrl.sv | 107 ++++++++++
 tb/tb_pht_access_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare front-end: history width, PHT counter
// encoding, the resolved-branch update record and the index hash.
package bp_pkg;

  localparam int unsigned HISTORY_LEN = 12;

  // 2-bit counter encoding; bit 1 is the predicted direction
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b11;
  localparam logic [1:0] CTR_ST  = 2'b10;

  typedef struct packed {
    logic [31:0]            pc;
    logic [HISTORY_LEN-1:0] hist;
    logic                   taken;
  } upd_entry_t;

  typedef enum logic [1:0] {
    ModeIdle,
    ModePred,
    ModeDrain
  } mode_e;

  function automatic logic [HISTORY_LEN-1:0] gshare_idx(input logic [31:0]            pc,
                                                        input logic [HISTORY_LEN-1:0] h);
    return pc[HISTORY_LEN+1:2] ^ h;
  endfunction

endpackage

// File: rtl/pht_access_ctrl_if.sv
// Signal bundle between fetch, the branch unit, the PHT and the gshare front-end.
// slave = the front-end itself; master = its environment.
interface pht_access_ctrl_if;

  localparam int unsigned HL = bp_pkg::HISTORY_LEN;

  logic          pred_valid;
  logic [31:0]   pred_pc;
  logic          pred_ready;
  logic          pred_taken;
  logic [HL-1:0] pred_hist;

  logic          upd_valid;
  logic [31:0]   upd_pc;
  logic [HL-1:0] upd_hist;
  logic          upd_taken;
  logic          upd_mispredict;
  logic          upd_ready;

  logic [HL-1:0] pht_index;
  logic          pht_write_en;
  logic          pht_taken;
  logic [1:0]    pht_counter;

  logic [HL-1:0] ghr;

  modport slave (
    input  pred_valid, pred_pc,
    output pred_ready, pred_taken, pred_hist,
    input  upd_valid, upd_pc, upd_hist, upd_taken, upd_mispredict,
    output upd_ready,
    output pht_index, pht_write_en, pht_taken,
    input  pht_counter,
    output ghr
  );

  modport master (
    output pred_valid, pred_pc,
    input  pred_ready, pred_taken, pred_hist,
    output upd_valid, upd_pc, upd_hist, upd_taken, upd_mispredict,
    input  upd_ready,
    input  pht_index, pht_write_en, pht_taken,
    output pht_counter,
    input  ghr
  );

endinterface

// File: rtl/bp_upd_fifo.sv
// Synchronous FIFO of resolved-branch updates awaiting a free PHT port cycle.
// Pointers carry one extra wrap bit to tell full from empty.
module bp_upd_fifo
  import bp_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       push_i,
  input  upd_entry_t push_data_i,
  input  logic       pop_i,
  output upd_entry_t pop_data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned Aw = $clog2(Depth);

  upd_entry_t    mem_q [Depth];
  logic [Aw:0]   wr_ptr_q, rd_ptr_q;
  logic          do_push, do_pop;

  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[Aw] != rd_ptr_q[Aw]) && (wr_ptr_q[Aw-1:0] == rd_ptr_q[Aw-1:0]);
  assign pop_data_o = mem_q[rd_ptr_q[Aw-1:0]];
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Payload storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[Aw-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/pht_access_ctrl.sv
// Gshare front-end: owns the speculative GHR, forms pc^GHR and shares the single PHT
// index port between fetch predictions and queued execute-stage training updates.
module pht_access_ctrl
  import bp_pkg::*;
#(
  parameter int unsigned UPD_DEPTH = 2,
  parameter int unsigned MAX_DEFER = 4
) (
  input logic               clk,
  input logic               rst_b,
  pht_access_ctrl_if.slave  bus
);

  localparam int unsigned HL     = HISTORY_LEN;
  localparam int unsigned DeferW = $clog2(MAX_DEFER + 1);

  logic [HL-1:0]     ghr_q, ghr_d;
  logic [DeferW-1:0] defer_q, defer_d;
  logic              defer_max;

  upd_entry_t head, push_entry;
  logic       fifo_full, fifo_empty;
  logic       push, pop, repair;
  mode_e      mode;

  assign defer_max  = (defer_q == DeferW'(MAX_DEFER));
  assign push       = bus.upd_valid && !fifo_full;
  assign repair     = push && bus.upd_mispredict;
  assign pop        = rst_b && (mode == ModeDrain);
  assign push_entry = '{pc: bus.upd_pc, hist: bus.upd_hist, taken: bus.upd_taken};

  bp_upd_fifo #(
    .Depth(UPD_DEPTH)
  ) u_upd_fifo (
    .clk         (clk),
    .rst_b       (rst_b),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .pop_data_o  (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Updates win when the FIFO is full or has been starved for MAX_DEFER cycles.
  always_comb begin
    mode = ModeIdle;
    if (!fifo_empty && (fifo_full || defer_max)) begin
      mode = ModeDrain;
    end else if (bus.pred_valid) begin
      mode = ModePred;
    end else if (!fifo_empty) begin
      mode = ModeDrain;
    end
  end

  assign bus.upd_ready  = !fifo_full;
  assign bus.pred_hist  = ghr_q;
  assign bus.pred_taken = bus.pht_counter[1];
  assign bus.ghr        = ghr_q;

  always_comb begin
    bus.pred_ready   = 1'b0;
    bus.pht_write_en = 1'b0;
    bus.pht_taken    = 1'b0;
    bus.pht_index    = gshare_idx(bus.pred_pc, ghr_q);
    case (mode)
      // Fetch is being redirected on a mispredict, so its request is refused.
      ModePred:  bus.pred_ready = rst_b && !repair;
      ModeDrain: begin
        bus.pht_index    = gshare_idx(head.pc, head.hist);
        bus.pht_taken    = head.taken;
        bus.pht_write_en = rst_b;
      end
      default: ;
    endcase
  end

  always_comb begin
    ghr_d = ghr_q;
    if (repair) begin
      ghr_d = {bus.upd_hist[HL-2:0], bus.upd_taken};
    end else if (bus.pred_ready) begin
      ghr_d = {ghr_q[HL-2:0], bus.pred_taken};
    end
  end

  always_comb begin
    defer_d = defer_q;
    if (pop || fifo_empty) begin
      defer_d = '0;
    end else if (mode == ModePred && !defer_max) begin
      defer_d = defer_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      ghr_q   <= '0;
      defer_q <= '0;
    end else begin
      ghr_q   <= ghr_d;
      defer_q <= defer_d;
    end
  end

endmodule

// File: tb/tb_pht_access_ctrl.sv
// Scoreboard bench for pht_access_ctrl: a queue/array reference model predicts each
// cycle's outputs; a negedge monitor pops and compares. Also holds a behavioural PHT.
module tb_pht_access_ctrl;

  localparam int HL    = 12;
  localparam int DEPTH = 2;
  localparam int MAXD  = 4;
  localparam int NENT  = 4096;

  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  pht_access_ctrl_if bus ();

  pht_access_ctrl #(
    .UPD_DEPTH(DEPTH),
    .MAX_DEFER(MAXD)
  ) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  logic [1:0] env_pht [NENT];
  logic [1:0] ref_pht [NENT];
  assign bus.pht_counter = env_pht[bus.pht_index];

  typedef struct {
    logic [31:0] pc;
    logic [11:0] hist;
    logic        taken;
  } upd_t;

  typedef struct {
    bit          in_rst;
    bit          pred_ready;
    bit          pred_taken;
    logic [11:0] pred_hist;
    bit          idx_valid;
    logic [11:0] idx;
    bit          we;
    bit          ptaken;
    bit          upd_ready;
    logic [11:0] ghr;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  upd_t        m_q[$];
  logic [11:0] m_ghr;
  int          m_defer;
  int          n_pass = 0;
  int          n_total = 0;

  logic        last_we, last_pr, last_ur;
  logic [11:0] last_idx;

  function automatic logic [11:0] idx_of(logic [31:0] pc, logic [11:0] h);
    return 12'(((pc >> 2) ^ {20'b0, h}) & 32'hFFF);
  endfunction

  // Counter strength order: SNT(00) < WNT(01) < WT(11) < ST(10)
  function automatic int lvl(logic [1:0] c);
    case (c)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] train(logic [1:0] c, logic t);
    logic [1:0] enc [4];
    int l;
    enc[0] = 2'b00; enc[1] = 2'b01; enc[2] = 2'b11; enc[3] = 2'b10;
    l = lvl(c);
    if (t && l < 3) l++;
    else if (!t && l > 0) l--;
    return enc[l];
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("pred_ready", 32'(bus.pred_ready), 32'(mon_e.pred_ready));
      chk("pht_write_en", 32'(bus.pht_write_en), 32'(mon_e.we));
      if (!mon_e.in_rst) begin
        chk("upd_ready", 32'(bus.upd_ready), 32'(mon_e.upd_ready));
        chk("ghr", 32'(bus.ghr), 32'(mon_e.ghr));
        if (mon_e.pred_ready) begin
          chk("pred_taken", 32'(bus.pred_taken), 32'(mon_e.pred_taken));
          chk("pred_hist", 32'(bus.pred_hist), 32'(mon_e.pred_hist));
        end
        if (mon_e.idx_valid) chk("pht_index", 32'(bus.pht_index), 32'(mon_e.idx));
        if (mon_e.we) chk("pht_taken", 32'(bus.pht_taken), 32'(mon_e.ptaken));
      end
    end
  end

  // One clock cycle: drive, predict, sample PHT port, advance env PHT and model.
  task automatic step(bit rb, bit pv, logic [31:0] ppc, bit uv, logic [31:0] upc,
                      logic [11:0] uh, bit ut, bit um);
    exp_t e;
    bit   full, drain, pred, accept, repair, was_empty;
    rst_b              = rb;
    bus.pred_valid     = pv;
    bus.pred_pc        = ppc;
    bus.upd_valid      = uv;
    bus.upd_pc         = upc;
    bus.upd_hist       = uh;
    bus.upd_taken      = ut;
    bus.upd_mispredict = um;

    full      = (m_q.size() == DEPTH);
    was_empty = (m_q.size() == 0);
    drain     = !was_empty && (full || m_defer == MAXD || !pv);
    pred      = !drain && pv;
    accept    = uv && !full;
    repair    = accept && um;

    e.in_rst     = !rb;
    e.upd_ready  = !full;
    e.ghr        = m_ghr;
    e.pred_hist  = m_ghr;
    e.pred_ready = rb && pred && !repair;
    e.we         = rb && drain;
    e.idx_valid  = rb && (drain || pred);
    if (drain) begin
      e.idx    = idx_of(m_q[0].pc, m_q[0].hist);
      e.ptaken = m_q[0].taken;
    end else begin
      e.idx    = idx_of(ppc, m_ghr);
      e.ptaken = 1'b0;
    end
    e.pred_taken = ref_pht[e.idx][1];
    exp_q.push_back(e);

    #3;
    last_we  = bus.pht_write_en;
    last_pr  = bus.pred_ready;
    last_ur  = bus.upd_ready;
    last_idx = bus.pht_index;
    @(posedge clk);
    if (last_we === 1'b1) env_pht[last_idx] = train(env_pht[last_idx], bus.pht_taken);

    if (!rb) begin
      m_q.delete();
      m_ghr   = '0;
      m_defer = 0;
    end else begin
      if (drain) begin
        ref_pht[e.idx] = train(ref_pht[e.idx], m_q[0].taken);
        void'(m_q.pop_front());
      end
      if (accept) m_q.push_back('{pc: upc, hist: uh, taken: ut});
      if (repair) m_ghr = 12'(((32'(uh) << 1) | 32'(ut)) & 32'hFFF);
      else if (e.pred_ready) m_ghr = 12'(((32'(m_ghr) << 1) | 32'(e.pred_taken)) & 32'hFFF);
      if (drain || was_empty) m_defer = 0;
      else if (pred && m_defer < MAXD) m_defer++;
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] v;
    rst_b = 1'b0;
    bus.pred_valid = 1'b0; bus.pred_pc = '0; bus.upd_valid = 1'b0; bus.upd_pc = '0;
    bus.upd_hist = '0; bus.upd_taken = 1'b0; bus.upd_mispredict = 1'b0;
    for (int i = 0; i < NENT; i++) begin
      v = 2'($urandom);
      env_pht[i] = v;
      ref_pht[i] = v;
    end
    env_pht[12'h040] = 2'b10; ref_pht[12'h040] = 2'b10;
    env_pht[12'h041] = 2'b00; ref_pht[12'h041] = 2'b00;
    env_pht[12'h042] = 2'b11; ref_pht[12'h042] = 2'b11;
    m_ghr = '0;
    m_defer = 0;
    @(posedge clk);
    #1;

    // Reset with a pending prediction request
    repeat (2) step(0, 1, 32'h100, 0, 0, 0, 0, 0);
    chk("t1_ghr_after_reset", 32'(bus.ghr), 32'h0);

    // Three back-to-back predictions at pc 0x100
    step(1, 1, 32'h100, 0, 0, 0, 0, 0);
    chk("t1_first_pred_accepted", 32'(last_pr), 32'h1);
    chk("t2_idx0", 32'(last_idx), 32'h040);
    step(1, 1, 32'h100, 0, 0, 0, 0, 0);
    step(1, 1, 32'h100, 0, 0, 0, 0, 0);
    chk("t2_ghr", 32'(bus.ghr), 32'h005);

    // Starved update is forced through on the 5th cycle
    step(1, 1, 32'h400, 1, 32'h2468, 12'h3C5, 1, 0);
    for (int k = 1; k <= 5; k++) begin
      step(1, 1, 32'h400 + 32'(k) * 4, 0, 0, 0, 0, 0);
      chk("t3_write_en", 32'(last_we), (k == 5) ? 32'h1 : 32'h0);
    end
    chk("t3_idx", 32'(last_idx), 32'hADF);

    // Fill the FIFO: it refuses a third update and drains ahead of fetch
    step(1, 1, 32'h800, 1, 32'h1000, 12'h111, 0, 0);
    step(1, 1, 32'h804, 1, 32'h2000, 12'h222, 1, 0);
    step(1, 1, 32'h808, 1, 32'h3000, 12'h333, 1, 0);
    chk("t4_upd_ready", 32'(last_ur), 32'h0);
    chk("t4_pred_ready", 32'(last_pr), 32'h0);
    chk("t4_write_en", 32'(last_we), 32'h1);
    repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0);

    // Mispredict repair beats a same-cycle prediction
    step(1, 1, 32'hC00, 1, 32'h5000, 12'hABC, 1, 1);
    chk("t5_pred_ready", 32'(last_pr), 32'h0);
    chk("t5_ghr", 32'(bus.ghr), 32'h579);

    // Reset with updates queued: they are discarded
    step(1, 1, 32'hC04, 1, 32'h6000, 12'h0F0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0, 0, 0, 0, 0);
      chk("t6_no_write", 32'(last_we), 32'h0);
    end
    chk("t6_ghr", 32'(bus.ghr), 32'h0);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0), $urandom,
           ($urandom_range(0, 2) == 0), $urandom, 12'($urandom), 1'($urandom),
           ($urandom_range(0, 3) == 0));
    end

    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
